fabric_config_loader: RTL and testbench
=======================================

# fabric_config_loader

Serial configuration loader that writes the fabric's configuration memory: logic-tile LUT/register-select words and switch-box routing words. It receives a framed, CRC-protected bitstream one bit per qualified clock and issues one parallel write per frame on a frame-write bus. It holds the fabric disabled until a complete, CRC-correct bitstream has been loaded.

## Interface
Parameters:
- FRAME_W, 33, frame payload width; covers a 32-entry LUT plus the register-select bit; switch-box words use bits [15:0]
- NUM_FRAMES, 58, number of addressable configuration frames
- ADDR_W, 6, frame address width; must satisfy 2^ADDR_W >= NUM_FRAMES

Ports:
- clock  input  1  sole clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; clears all state
- cfg_valid  input  1  qualifies cfg_bit; when low, the loader holds all state
- cfg_bit  input  1  serial bitstream bit, LSB-first within every field
- frame_we  output  1  one-cycle write strobe
- frame_addr  output  ADDR_W  target frame; valid while frame_we is high
- frame_data  output  FRAME_W  frame payload; valid while frame_we is high
- busy  output  1  high from sync detection until DONE or ERROR
- config_done  output  1  sticky; high when the bitstream is complete and the CRC is correct
- config_error  output  1  sticky; high on a bad count, bad address, or CRC mismatch
- fabric_enable  output  1  equals config_done; the fabric's clear must be held while this is low

## Operation
- Bitstream format: sync byte 8'hA5, then an 8-bit frame count N, then N records of {ADDR_W address bits, FRAME_W data bits}, then an 8-bit CRC.
- States:
  - HUNT: shift cfg_bit into an 8-bit register (new bit enters at the MSB, LSB-first order). When the register equals 8'hA5, go to COUNT, reset the CRC, and set busy.
  - COUNT: receive 8 bits of N. If N == 0 or N > NUM_FRAMES, go to ERROR. Otherwise load the frame counter and go to ADDR.
  - ADDR: receive ADDR_W bits. If the address is >= NUM_FRAMES, go to ERROR with no write. Otherwise go to DATA.
  - DATA: receive FRAME_W bits. On the last bit, register frame_addr and frame_data, pulse frame_we, and decrement the frame counter. If the counter reaches zero, go to CRC; otherwise go to ADDR.
  - CRC: receive 8 bits. If they equal the running CRC, go to DONE; otherwise go to ERROR.
  - DONE: config_done = 1, busy = 0. Stay in DONE, hunting for sync in parallel. A new 8'hA5 clears config_done and re-enters COUNT, which reconfigures the fabric.
  - ERROR: config_error = 1, busy = 0, config_done = 0. Only reset exits this state, so the fabric stays disabled.
- CRC: CRC-8, polynomial 0x07, init 0x00, serial form. For each bit: fb = crc[7] ^ bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
  - Computed over every count, address and data bit, in arrival order; the sync byte and the CRC byte are excluded.
- Bit counters are sized for FRAME_W. The frame counter is 8 bits wide.
- Frames already written when an error is detected are not rolled back. Containment relies on fabric_enable staying low.
- Duplicate addresses are allowed; the last write wins.

## Timing
- Reset values: frame_we=0, frame_addr=0, frame_data=0, busy=0, config_done=0, config_error=0, fabric_enable=0, state=HUNT, CRC=0.
- Every state or counter advance requires cfg_valid=1 at the rising edge. With cfg_valid=0 nothing changes and frame_we stays 0.
- frame_we goes high in the cycle after the edge that samples the last data bit of a frame and lasts exactly one cycle.
  - It is high for one cycle even if cfg_valid is low in that cycle.
- Back-to-back frames: minimum spacing between frame_we pulses is ADDR_W+FRAME_W qualified cycles (39 by default).
- busy rises in the cycle after the edge that samples the eighth sync bit.
- config_done / config_error rise in the cycle after the edge that samples the last CRC bit, or the offending count/address bit.
- Latency, sync start to config_done, with continuous cfg_valid: 8+8+N*(ADDR_W+FRAME_W)+8 cycles.
- An asynchronous reset mid-frame aborts immediately. No frame_we is issued for a partial frame, and HUNT restarts on release.
- A sync pattern arriving inside COUNT, ADDR, DATA or CRC is treated as payload; no resync.

## Test plan
- Good single frame: sync, N=1, addr=5, data=33'h1_0000_0001, correct CRC -> one frame_we with addr 5 / data 33'h100000001; config_done=1 and fabric_enable=1 exactly 8 qualified cycles later.
- Bad CRC: the same stream with CRC bit 0 flipped -> frame_we still fires once; then config_error=1, config_done=0, fabric_enable=0; a further valid stream is ignored until reset.
- Range errors: N=0 -> error after 8 count bits, no writes; N=2 with second addr=58 -> exactly one write, then error with no second frame_we.
- Stall insertion: full 3-frame stream with cfg_valid pseudo-randomly low 50% of cycles -> same three writes and data as the unstalled run, config_done=1.
- Reset mid-DATA: assert reset after 20 data bits of frame 2 -> all outputs return to 0 immediately, no frame_we for frame 2; a full stream after release loads correctly.
- Reconfiguration: after DONE, send a new sync plus a 1-frame stream -> config_done falls on sync detection, rewrites the frame, and config_done rises again.

Source files
------------

// File: rtl/fabric_config_loader.sv
// fabric_config_loader
//   Serial configuration loader for the fabric configuration memory. Hunts for a
//   sync byte, then receives a frame count, N {address, data} records and a CRC-8,
//   all LSB-first, one bit per cycle with cfg_valid high. Each record produces one
//   single-cycle write on the frame-write bus. The fabric stays disabled until a
//   complete, CRC-correct bitstream has been received.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   cfg_valid     qualifies cfg_bit; when low nothing advances
//   cfg_bit       serial bitstream bit
//   frame_we      one-cycle frame write strobe
//   frame_addr    frame address, valid with frame_we
//   frame_data    frame payload, valid with frame_we
//   busy          high between sync detection and DONE/ERROR
//   config_done   high while a good bitstream is in place
//   config_error  high after a bad count, bad address or CRC mismatch (until reset)
//   fabric_enable mirror of config_done
module fabric_config_loader #(
  parameter int unsigned FRAME_W    = 33,
  parameter int unsigned NUM_FRAMES = 58,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               frame_we,
  output logic [ADDR_W-1:0]  frame_addr,
  output logic [FRAME_W-1:0] frame_data,
  output logic               busy,
  output logic               config_done,
  output logic               config_error,
  output logic               fabric_enable
);

  localparam int unsigned CntW = $clog2(FRAME_W + 1);
  localparam int unsigned AddrW1 = ADDR_W + 1;

  localparam logic [CntW-1:0]   LastByte  = CntW'(7);
  localparam logic [CntW-1:0]   LastAddr  = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0]   LastData  = CntW'(FRAME_W - 1);
  localparam logic [7:0]        NumFrames8 = 8'(NUM_FRAMES);
  // One extra bit so NUM_FRAMES == 2^ADDR_W is still representable.
  localparam logic [ADDR_W:0]   NumFramesA = AddrW1'(NUM_FRAMES);
  localparam logic [7:0]        SyncByte  = 8'hA5;

  localparam logic [2:0] StHunt  = 3'd0;
  localparam logic [2:0] StCount = 3'd1;
  localparam logic [2:0] StAddr  = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StCrc   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StError = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [7:0]         sync_q, sync_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]         frames_q, frames_d;
  logic [7:0]         crc_q, crc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               frame_we_q, frame_we_d;
  logic [ADDR_W-1:0]  frame_addr_q, frame_addr_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;

  logic [7:0]         sync_shift;
  logic [FRAME_W-1:0] shreg_shift;
  logic [7:0]         field8;
  logic [ADDR_W-1:0]  field_addr;
  logic               crc_fb;
  logic [7:0]         crc_next;

  // Fields arrive LSB-first and enter at the MSB, so a completed W-bit field sits
  // in the top W bits of the shift register.
  assign sync_shift  = {cfg_bit, sync_q[7:1]};
  assign shreg_shift = {cfg_bit, shreg_q[FRAME_W-1:1]};
  assign field8      = shreg_shift[FRAME_W-1 -: 8];
  assign field_addr  = shreg_shift[FRAME_W-1 -: ADDR_W];
  assign crc_fb      = crc_q[7] ^ cfg_bit;
  assign crc_next    = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frames_d     = frames_q;
    crc_d        = crc_q;
    addr_d       = addr_q;
    frame_we_d   = 1'b0;
    frame_addr_d = frame_addr_q;
    frame_data_d = frame_data_q;

    if (cfg_valid) begin
      case (state_q)
        StHunt, StDone: begin
          sync_d = sync_shift;
          if (sync_shift == SyncByte) begin
            state_d   = StCount;
            // Cleared so a later hunt in DONE needs eight fresh bits.
            sync_d    = '0;
            crc_d     = '0;
            bit_cnt_d = '0;
          end
        end
        StCount: begin
          shreg_d = shreg_shift;
          crc_d   = crc_next;
          if (bit_cnt_q == LastByte) begin
            bit_cnt_d = '0;
            if (field8 == 8'd0 || field8 > NumFrames8) begin
              state_d = StError;
            end else begin
              frames_d = field8;
              state_d  = StAddr;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StAddr: begin
          shreg_d = shreg_shift;
          crc_d   = crc_next;
          if (bit_cnt_q == LastAddr) begin
            bit_cnt_d = '0;
            if ({1'b0, field_addr} >= NumFramesA) begin
              state_d = StError;
            end else begin
              addr_d  = field_addr;
              state_d = StData;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StData: begin
          shreg_d = shreg_shift;
          crc_d   = crc_next;
          if (bit_cnt_q == LastData) begin
            bit_cnt_d    = '0;
            frame_we_d   = 1'b1;
            frame_addr_d = addr_q;
            frame_data_d = shreg_shift;
            frames_d     = frames_q - 8'd1;
            state_d      = (frames_q == 8'd1) ? StCrc : StAddr;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StCrc: begin
          // The CRC byte itself is not folded into the running CRC.
          shreg_d = shreg_shift;
          if (bit_cnt_q == LastByte) begin
            bit_cnt_d = '0;
            state_d   = (field8 == crc_q) ? StDone : StError;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StError: ;
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StHunt;
      sync_q       <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      frames_q     <= '0;
      crc_q        <= '0;
      addr_q       <= '0;
      frame_we_q   <= 1'b0;
      frame_addr_q <= '0;
      frame_data_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      frames_q     <= frames_d;
      crc_q        <= crc_d;
      addr_q       <= addr_d;
      frame_we_q   <= frame_we_d;
      frame_addr_q <= frame_addr_d;
      frame_data_q <= frame_data_d;
    end
  end

  assign frame_we      = frame_we_q;
  assign frame_addr    = frame_addr_q;
  assign frame_data    = frame_data_q;
  assign busy          = (state_q == StCount) || (state_q == StAddr) ||
                         (state_q == StData)  || (state_q == StCrc);
  assign config_done   = (state_q == StDone);
  assign config_error  = (state_q == StError);
  assign fabric_enable = config_done;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for fabric_config_loader: directed bitstreams, expected frame writes go
// into a scoreboard queue that a negedge monitor drains on every frame_we.
module tb_fabric_config_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        frame_we;
  logic [5:0]  frame_addr;
  logic [32:0] frame_data;
  logic        busy;
  logic        config_done;
  logic        config_error;
  logic        fabric_enable;

  typedef struct packed {
    logic [5:0]  a;
    logic [32:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] crc_acc = 8'h00;
  bit         crc_on = 1'b0;
  bit         stall_on = 1'b0;

  fabric_config_loader #(
    .FRAME_W   (33),
    .NUM_FRAMES(58),
    .ADDR_W    (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_bit      (cfg_bit),
    .frame_we     (frame_we),
    .frame_addr   (frame_addr),
    .frame_data   (frame_data),
    .busy         (busy),
    .config_done  (config_done),
    .config_error (config_error),
    .fabric_enable(fabric_enable)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    exp_t e;
    if (frame_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 frame_addr, frame_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {58'd0, frame_addr}, {58'd0, e.a});
        chk("wr_data", {31'd0, frame_data}, {31'd0, e.d});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    int k;
    k = 0;
    if (stall_on) begin
      while (k < 6 && $urandom_range(0, 1) == 1) begin
        cfg_valid = 1'b0;
        cfg_bit   = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
        k++;
      end
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    if (crc_on) crc_acc = {crc_acc[6:0], 1'b0} ^ ((crc_acc[7] ^ b) ? 8'h07 : 8'h00);
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_field(input logic [63:0] v, input int w);
    for (int i = 0; i < w; i++) send_bit(v[i]);
  endtask

  task automatic send_sync();
    crc_on = 1'b0;
    send_field(64'hA5, 8);
    crc_acc = 8'h00;
    crc_on  = 1'b1;
  endtask

  task automatic send_crc(input logic [7:0] flip);
    logic [7:0] c;
    c      = crc_acc ^ flip;
    crc_on = 1'b0;
    send_field({56'd0, c}, 8);
  endtask

  task automatic send_rec(input logic [5:0] a, input logic [32:0] d, input bit expect_wr);
    if (expect_wr) exp_q.push_back('{a: a, d: d});
    send_field({58'd0, a}, 6);
    send_field({31'd0, d}, 33);
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic run3(input bit stall);
    do_reset();
    stall_on = stall;
    send_sync();
    send_field(64'd3, 8);
    send_rec(6'd0,  33'h1_FFFF_FFFF, 1'b1);
    send_rec(6'd57, 33'h0_1234_5678, 1'b1);
    send_rec(6'd10, 33'h1_8000_0001, 1'b1);
    send_crc(8'h00);
    stall_on = 1'b0;
    chk(stall ? "stall_done" : "nostall_done", {63'd0, config_done}, 64'd1);
  endtask

  initial begin
    logic [7:0] c;

    // Reset values, sampled while reset is held.
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we",     {63'd0, frame_we},      64'd0);
    chk("rst_addr",   {58'd0, frame_addr},    64'd0);
    chk("rst_data",   {31'd0, frame_data},    64'd0);
    chk("rst_busy",   {63'd0, busy},          64'd0);
    chk("rst_done",   {63'd0, config_done},   64'd0);
    chk("rst_err",    {63'd0, config_error},  64'd0);
    chk("rst_enable", {63'd0, fabric_enable}, 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Good single frame; done rises exactly on the 8th CRC bit after the write.
    send_sync();
    chk("t1_busy", {63'd0, busy}, 64'd1);
    send_field(64'd1, 8);
    send_rec(6'd5, 33'h1_0000_0001, 1'b1);
    chk("t1_we", {63'd0, frame_we}, 64'd1);
    c      = crc_acc;
    crc_on = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    chk("t1_done_early", {63'd0, config_done}, 64'd0);
    send_bit(c[7]);
    chk("t1_done",   {63'd0, config_done},   64'd1);
    chk("t1_enable", {63'd0, fabric_enable}, 64'd1);
    chk("t1_busy_lo", {63'd0, busy},         64'd0);

    // Reconfiguration from DONE.
    send_sync();
    chk("rc_done_lo", {63'd0, config_done}, 64'd0);
    chk("rc_busy",    {63'd0, busy},        64'd1);
    send_field(64'd1, 8);
    send_rec(6'd5, 33'h0_DEAD_BEEF, 1'b1);
    send_crc(8'h00);
    chk("rc_done", {63'd0, config_done}, 64'd1);

    // Bad CRC: write still happens, then sticky error.
    do_reset();
    send_sync();
    send_field(64'd1, 8);
    send_rec(6'd5, 33'h1_0000_0001, 1'b1);
    send_crc(8'h01);
    chk("bc_err",    {63'd0, config_error},  64'd1);
    chk("bc_done",   {63'd0, config_done},   64'd0);
    chk("bc_enable", {63'd0, fabric_enable}, 64'd0);
    send_sync();
    send_field(64'd1, 8);
    send_rec(6'd9, 33'h0_0000_00FF, 1'b0);
    send_crc(8'h00);
    chk("bc_err_sticky", {63'd0, config_error}, 64'd1);
    chk("bc_done_sticky", {63'd0, config_done}, 64'd0);

    // N = 0.
    do_reset();
    send_sync();
    send_field(64'd0, 8);
    chk("n0_err",  {63'd0, config_error}, 64'd1);
    chk("n0_busy", {63'd0, busy},         64'd0);

    // N = 59 exceeds the frame count.
    do_reset();
    send_sync();
    send_field(64'd59, 8);
    chk("n59_err", {63'd0, config_error}, 64'd1);

    // N = 2 with an out-of-range second address.
    do_reset();
    send_sync();
    send_field(64'd2, 8);
    send_rec(6'd3, 33'h0_0F0F_0F0F, 1'b1);
    send_field(64'd58, 6);
    chk("badaddr_err", {63'd0, config_error}, 64'd1);
    send_field(64'h1_2345_6789, 33);
    chk("badaddr_we", {63'd0, frame_we}, 64'd0);

    // Unstalled, then stalled 3-frame stream.
    run3(1'b0);
    run3(1'b1);

    // Reset in the middle of frame 2 data.
    do_reset();
    send_sync();
    send_field(64'd3, 8);
    send_rec(6'd1, 33'h0_AAAA_5555, 1'b1);
    send_field(64'd2, 6);
    send_field(64'h0_000F_FFFF, 20);
    reset = 1'b0;
    #2;
    chk("mid_we",   {63'd0, frame_we},     64'd0);
    chk("mid_addr", {58'd0, frame_addr},   64'd0);
    chk("mid_data", {31'd0, frame_data},   64'd0);
    chk("mid_busy", {63'd0, busy},         64'd0);
    chk("mid_err",  {63'd0, config_error}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send_sync();
    send_field(64'd1, 8);
    send_rec(6'd20, 33'h1_CAFE_F00D, 1'b1);
    send_crc(8'h00);
    chk("mid_reload_done", {63'd0, config_done}, 64'd1);

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
